shift_32_bit_serial: RTL



---
 rtl/shift_pkg.sv | 16 +
 rtl/shift_step_1bit.sv | 28 ++
 rtl/shift_32_bit_serial.sv | 112 +++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the serial shifter family.
//   SHIFT_WIDTH : default datapath width
//   S_*         : FSM state encodings (kept as plain constants so legacy
//                 code that compares raw state values keeps working)
//   DIR_LEFT    : value of the direction flag that selects a left shift
package shift_pkg;

  localparam int SHIFT_WIDTH = 32;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_SHIFT = 2'b01;
  localparam logic [1:0] S_DONE  = 2'b10;

  localparam logic DIR_LEFT = 1'b1;

endpackage

// File: rtl/shift_step_1bit.sv
// Combinational single-bit shift step, shared with wider-per-cycle variants.
// Ports:
//   regIn   [WIDTH-1:0] : current shift register value
//   dir                 : DIR_LEFT selects left, otherwise right
//   arith               : sign-fill on right shifts; ignored for left shifts
//   regNext [WIDTH-1:0] : value after one bit of shifting
module shift_step_1bit
  import shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH
) (
  input  logic [WIDTH-1:0] regIn,
  input  logic             dir,
  input  logic             arith,
  output logic [WIDTH-1:0] regNext
);

  always_comb begin
    regNext = regIn;
    if (dir == DIR_LEFT) begin
      regNext = {regIn[WIDTH-2:0], 1'b0};
    end else begin
      // Arithmetic fill replicates the sign bit; logical fill is zero.
      regNext = {arith & regIn[WIDTH-1], regIn[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/shift_32_bit_serial.sv
// Multi-cycle serial shifter: one bit per clock, start/busy/done handshake.
// Supports logical left, logical right and arithmetic right shifts.
// Ports:
//   clk         : rising-edge clock
//   rst         : asynchronous active-low reset
//   start       : request, only sampled while idle
//   in          [WIDTH-1:0] : operand
//   shiftAmt    [31:0]      : unsigned shift amount, >= WIDTH saturates
//   LeftOrRight : 1 = left, 0 = right
//   isArith     : 1 = arithmetic (right shifts only)
//   out         [WIDTH-1:0] : shift register, valid from done onward
//   busy        : high whenever the FSM is not idle
//   done        : single-cycle completion pulse
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | waiting for start; out holds the last result
// S_SHIFT | shifting one bit per cycle until the counter expires
// S_DONE  | result complete, done pulses for this one cycle
module shift_32_bit_serial
  import shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [31:0]      shiftAmt,
  input  logic             LeftOrRight,
  input  logic             isArith,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] loadCnt;
  logic             dirReg;
  logic             arithReg;
  logic [WIDTH-1:0] stepNext;

  // The full 32-bit amount is compared so large values saturate rather
  // than wrapping through the truncated counter.
  always_comb begin
    loadCnt = shiftAmt[CNT_W-1:0];
    if (shiftAmt >= 32'(WIDTH)) begin
      loadCnt = CNT_W'(WIDTH);
    end
  end

  shift_step_1bit #(
    .WIDTH(WIDTH)
  ) uStep (
    .regIn  (out),
    .dir    (dirReg),
    .arith  (arithReg),
    .regNext(stepNext)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      out      <= '0;
      dirReg   <= 1'b0;
      arithReg <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            out      <= in;
            dirReg   <= LeftOrRight;
            arithReg <= isArith;
            cnt      <= loadCnt;
            busy     <= 1'b1;
            if (loadCnt != '0) begin
              state <= S_SHIFT;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          out <= stepNext;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
